// File: rtl/axi_rd_arbiter2_if.sv
// AXI read-channel bundle (AR + R) shared by the arbiter's master-facing
// ports and its slave-facing port. The master modport is the side that
// issues AR requests and consumes R beats; the slave modport is the other side.
interface axi_rd_arbiter2_if #(
  parameter int WIDTH_ID = 4,
  parameter int WIDTH_AD = 32,
  parameter int WIDTH_DA = 32
);
`ifdef AMBA_AXI4
  localparam int LEN_W  = 8;
  localparam int LOCK_W = 1;
`else
  localparam int LEN_W  = 4;
  localparam int LOCK_W = 2;
`endif

  logic [WIDTH_ID-1:0] arid;
  logic [WIDTH_AD-1:0] araddr;
  logic [LEN_W-1:0]    arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic [LOCK_W-1:0]   arlock;
  logic                arvalid;
  logic                arready;

  logic [WIDTH_ID-1:0] rid;
  logic [WIDTH_DA-1:0] rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_rd_arbiter2.sv
// Two-master to one-slave AXI read arbiter. Round-robin grant on AR with a
// registered grant cycle, master index prepended to ARID, R beats routed
// back by the RID MSB, and a per-master outstanding-burst limit.
module axi_rd_arbiter2 #(
  parameter int WIDTH_ID = 4,
  parameter int WIDTH_AD = 32,
  parameter int WIDTH_DA = 32,
  parameter int MAX_OUT  = 4
) (
  input  logic ACLK,
  input  logic ARESETn,
  axi_rd_arbiter2_if.slave  m0,
  axi_rd_arbiter2_if.slave  m1,
  axi_rd_arbiter2_if.master s
);

  typedef enum logic {IDLE, BUSY} st_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_OUT);

  st_t                 st, st_nxt;
  logic                gnt, gnt_nxt;
  logic                prio, prio_nxt;
  logic [3:0]          cnt_0, cnt_1;
  logic                req_0, req_1;
  logic                ar_hs;
  logic                r_sel;
  logic                inc_0, inc_1, dec_0, dec_1;
  logic [WIDTH_AD-1:0] sel_addr;
  logic [WIDTH_DA-1:0] r_data;

  // Eligible requests and handshake/accounting events
  always_comb begin
    req_0 = m0.arvalid && (cnt_0 < MAX_CNT);
    req_1 = m1.arvalid && (cnt_1 < MAX_CNT);
    ar_hs = s.arvalid && s.arready;
    inc_0 = ar_hs && !gnt;
    inc_1 = ar_hs && gnt;
    dec_0 = s.rvalid && s.rready && s.rlast && !r_sel;
    dec_1 = s.rvalid && s.rready && s.rlast && r_sel;
  end

  // State, grant, priority and outstanding counters
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      st    <= IDLE;
      gnt   <= 1'b0;
      prio  <= 1'b0;
      cnt_0 <= '0;
      cnt_1 <= '0;
    end else begin
      st   <= st_nxt;
      gnt  <= gnt_nxt;
      prio <= prio_nxt;
      if (inc_0 && !dec_0)      cnt_0 <= cnt_0 + 4'd1;
      else if (dec_0 && !inc_0) cnt_0 <= cnt_0 - 4'd1;
      if (inc_1 && !dec_1)      cnt_1 <= cnt_1 + 4'd1;
      else if (dec_1 && !inc_1) cnt_1 <= cnt_1 - 4'd1;
    end
  end

  // Next-state: pick a master in IDLE, release the slave port on handshake
  always_comb begin
    st_nxt   = st;
    gnt_nxt  = gnt;
    prio_nxt = prio;
    case (st)
      IDLE: begin
        if (req_0 || req_1) begin
          st_nxt  = BUSY;
          gnt_nxt = (req_0 && req_1) ? prio : req_1;
        end
      end
      BUSY: begin
        if (ar_hs) begin
          st_nxt   = IDLE;
          prio_nxt = ~gnt;
        end
      end
    endcase
  end

  // AR path: pass the granted master straight through while BUSY
  always_comb begin
    sel_addr   = gnt ? m1.araddr : m0.araddr;
    s.arid     = {gnt, (gnt ? m1.arid : m0.arid)};
    s.araddr   = sel_addr;
    s.arlen    = gnt ? m1.arlen   : m0.arlen;
    s.arsize   = gnt ? m1.arsize  : m0.arsize;
    s.arburst  = gnt ? m1.arburst : m0.arburst;
    s.arlock   = gnt ? m1.arlock  : m0.arlock;
    s.arvalid  = (st == BUSY) && (gnt ? m1.arvalid : m0.arvalid);
    m0.arready = (st == BUSY) && !gnt && s.arready;
    m1.arready = (st == BUSY) && gnt && s.arready;
  end

  // R path: route by RID MSB, broadcast payload, zero latency
  always_comb begin
    r_sel     = s.rid[WIDTH_ID];
    r_data    = s.rdata;
    m0.rvalid = s.rvalid && !r_sel;
    m1.rvalid = s.rvalid && r_sel;
    m0.rid    = s.rid[WIDTH_ID-1:0];
    m1.rid    = s.rid[WIDTH_ID-1:0];
    m0.rdata  = r_data;
    m1.rdata  = r_data;
    m0.rresp  = s.rresp;
    m1.rresp  = s.rresp;
    m0.rlast  = s.rlast;
    m1.rlast  = s.rlast;
    s.rready  = r_sel ? m1.rready : m0.rready;
  end

endmodule

// File: tb/tb_axi_rd_arbiter2.sv
// Bench for axi_rd_arbiter2: directed scenarios with literal expectations,
// then a long randomized run, all cross-checked every cycle against a
// transaction-level model of the arbiter.
module tb_axi_rd_arbiter2;
  localparam int ID_W    = 4;
  localparam int MAX_OUT = 2;

  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  int total = 0;
  int bad = 0;

  axi_rd_arbiter2_if #(.WIDTH_ID(ID_W),   .WIDTH_AD(32), .WIDTH_DA(32)) m0_if ();
  axi_rd_arbiter2_if #(.WIDTH_ID(ID_W),   .WIDTH_AD(32), .WIDTH_DA(32)) m1_if ();
  axi_rd_arbiter2_if #(.WIDTH_ID(ID_W+1), .WIDTH_AD(32), .WIDTH_DA(32)) s_if ();

  axi_rd_arbiter2 #(.WIDTH_ID(ID_W), .WIDTH_AD(32), .WIDTH_DA(32), .MAX_OUT(MAX_OUT)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .m0(m0_if), .m1(m1_if), .s(s_if)
  );

  always #5 ACLK = ~ACLK;

  // per-master views for the model
  logic            av [2];
  logic            rr [2];
  logic [ID_W-1:0] mid [2];
  logic [31:0]     maddr [2];
  logic [7:0]      mlen [2];
  assign av[0] = m0_if.arvalid;  assign av[1] = m1_if.arvalid;
  assign rr[0] = m0_if.rready;   assign rr[1] = m1_if.rready;
  assign mid[0] = m0_if.arid;    assign mid[1] = m1_if.arid;
  assign maddr[0] = m0_if.araddr; assign maddr[1] = m1_if.araddr;
  assign mlen[0] = 8'(m0_if.arlen); assign mlen[1] = 8'(m1_if.arlen);

  // model: who owns the slave AR port (-1 = nobody), who wins a tie, bursts in flight
  int own = -1;
  int turn = 0;
  int outst [2];

  function automatic int rtgt();
    return s_if.rid[ID_W] ? 1 : 0;
  endfunction

  function automatic logic eligible(int k);
    return av[k] && (outst[k] < MAX_OUT);
  endfunction

  function automatic logic accepted();
    return (own >= 0) && av[own] && s_if.arready;
  endfunction

  function automatic int f_own();
    if (own < 0) begin
      if (eligible(0) && eligible(1)) return turn;
      if (eligible(0)) return 0;
      if (eligible(1)) return 1;
      return -1;
    end
    return accepted() ? -1 : own;
  endfunction

  function automatic int f_turn();
    return accepted() ? 1 - own : turn;
  endfunction

  function automatic int f_cnt(int k);
    int c = outst[k];
    if (accepted() && own == k) c++;
    if (s_if.rvalid && s_if.rlast && rr[k] && rtgt() == k) c--;
    return c;
  endfunction

  always @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      own <= -1;
      turn <= 0;
      outst[0] <= 0;
      outst[1] <= 0;
    end else begin
      own <= f_own();
      turn <= f_turn();
      outst[0] <= f_cnt(0);
      outst[1] <= f_cnt(1);
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // handshake flags observed mid-cycle, consumed by the random driver
  logic f_s_hs, f_r_hs;
  logic f_m_hs [2];
  int   f_s_id, f_s_len;
  logic exp_sav;

  // every-cycle comparison against the model
  always @(negedge ACLK) begin
    exp_sav = (own >= 0) ? av[own] : 1'b0;
    check("s_arvalid", s_if.arvalid, exp_sav);
    check("m0_arready", m0_if.arready, (own == 0) && s_if.arready);
    check("m1_arready", m1_if.arready, (own == 1) && s_if.arready);
    if (exp_sav) begin
      check("s_arid", s_if.arid, {(own == 1), mid[own]});
      check("s_araddr", s_if.araddr, maddr[own]);
      check("s_arlen", 8'(s_if.arlen), mlen[own]);
    end
    check("m0_rvalid", m0_if.rvalid, s_if.rvalid && rtgt() == 0);
    check("m1_rvalid", m1_if.rvalid, s_if.rvalid && rtgt() == 1);
    if (s_if.rvalid) begin
      check("r_rid", (rtgt() == 0) ? m0_if.rid : m1_if.rid, s_if.rid[ID_W-1:0]);
      check("m0_rdata", m0_if.rdata, s_if.rdata);
      check("m1_rdata", m1_if.rdata, s_if.rdata);
      check("r_rlast", (rtgt() == 0) ? m0_if.rlast : m1_if.rlast, s_if.rlast);
    end
    check("s_rready", s_if.rready, rr[rtgt()]);
    check("cnt_0", dut.cnt_0, outst[0]);
    check("cnt_1", dut.cnt_1, outst[1]);
    f_s_hs   <= s_if.arvalid && s_if.arready;
    f_s_id   <= int'(s_if.arid);
    f_s_len  <= int'(s_if.arlen);
    f_r_hs   <= s_if.rvalid && s_if.rready;
    f_m_hs[0] <= m0_if.arvalid && m0_if.arready;
    f_m_hs[1] <= m1_if.arvalid && m1_if.arready;
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic drive_m(input int k, input logic v, input logic [ID_W-1:0] id,
                         input logic [31:0] addr, input logic [1:0] len);
    if (k == 0) begin
      m0_if.arvalid = v; m0_if.arid = id; m0_if.araddr = addr;
      m0_if.arlen = '0; m0_if.arlen[1:0] = len;
      m0_if.arsize = 3'd2; m0_if.arburst = 2'd1; m0_if.arlock = '0;
    end else begin
      m1_if.arvalid = v; m1_if.arid = id; m1_if.araddr = addr;
      m1_if.arlen = '0; m1_if.arlen[1:0] = len;
      m1_if.arsize = 3'd2; m1_if.arburst = 2'd1; m1_if.arlock = '0;
    end
  endtask

  task automatic drive_r(input logic v, input logic [ID_W:0] id, input logic last,
                         input logic [31:0] data);
    s_if.rvalid = v; s_if.rid = id; s_if.rlast = last; s_if.rdata = data; s_if.rresp = 2'd0;
  endtask

  task automatic do_reset();
    @(posedge ACLK);
    #1;
    ARESETn = 1'b0;
    drive_m(0, 1'b0, '0, '0, 2'd0);
    drive_m(1, 1'b0, '0, '0, 2'd0);
    drive_r(1'b0, '0, 1'b0, '0);
    s_if.arready = 1'b0;
    m0_if.rready = 1'b0;
    m1_if.rready = 1'b0;
    repeat (2) @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
  endtask

  // random traffic: AXI-legal holds on ARVALID/RVALID, in-order slave returns
  int q_id[$];
  int q_beats[$];

  task automatic rnd_step();
    if (f_s_hs) begin
      q_id.push_back(f_s_id);
      q_beats.push_back(f_s_len + 1);
    end
    if (s_if.rvalid && f_r_hs) begin
      q_beats[0] = q_beats[0] - 1;
      if (q_beats[0] == 0) begin
        void'(q_id.pop_front());
        void'(q_beats.pop_front());
      end
    end
    if (!(s_if.rvalid && !f_r_hs)) begin
      if (q_id.size() > 0 && ($urandom % 4) != 0)
        drive_r(1'b1, (ID_W+1)'(q_id[0]), q_beats[0] == 1, $urandom);
      else
        s_if.rvalid = 1'b0;
    end
    for (int k = 0; k < 2; k++)
      if (!(av[k] && !f_m_hs[k]))
        drive_m(k, ($urandom % 3) != 0, ID_W'($urandom), $urandom, 2'($urandom));
    s_if.arready = ($urandom % 4) != 0;
    m0_if.rready = ($urandom % 3) != 0;
    m1_if.rready = ($urandom % 3) != 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int hs_n;
    int hs_cyc [8];
    logic hs_msb [8];
    int b;
    int c;
    logic rdy;

    drive_m(0, 1'b0, '0, '0, 2'd0);
    drive_m(1, 1'b0, '0, '0, 2'd0);
    drive_r(1'b0, '0, 1'b0, '0);
    s_if.arready = 1'b0;
    m0_if.rready = 1'b0;
    m1_if.rready = 1'b0;

    // reset state
    @(negedge ACLK);
    check("rst_s_arvalid", s_if.arvalid, 1'b0);
    check("rst_m0_arready", m0_if.arready, 1'b0);
    check("rst_m1_arready", m1_if.arready, 1'b0);
    check("rst_cnt_0", dut.cnt_0, 4'd0);

    // single read from M0
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      if (i == 0) begin drive_m(0, 1'b1, 4'd3, 32'h10, 2'd0); s_if.arready = 1'b1; end
      if (i == 2) drive_m(0, 1'b0, 4'd3, 32'h10, 2'd0);
      if (i == 3) begin drive_r(1'b1, 5'h03, 1'b1, 32'hCAFE_F00D); m0_if.rready = 1'b1; end
      if (i == 4) s_if.rvalid = 1'b0;
      @(negedge ACLK);
      if (i == 0) check("t1_sav_c0", s_if.arvalid, 1'b0);
      if (i == 1) begin
        check("t1_sav_c1", s_if.arvalid, 1'b1);
        check("t1_sarid", s_if.arid, 5'h03);
        check("t1_saraddr", s_if.araddr, 32'h10);
        check("t1_m0ardy", m0_if.arready, 1'b1);
      end
      if (i == 2) check("t1_cnt_after_ar", dut.cnt_0, 4'd1);
      if (i == 3) begin
        check("t1_m0_rvalid", m0_if.rvalid, 1'b1);
        check("t1_m0_rid", m0_if.rid, 4'd3);
        check("t1_m1_rvalid", m1_if.rvalid, 1'b0);
        check("t1_m0_rdata", m0_if.rdata, 32'hCAFE_F00D);
      end
      if (i == 4) check("t1_cnt_after_r", dut.cnt_0, 4'd0);
    end

    // contention: alternating grants, then both masters at the limit
    do_reset();
    hs_n = 0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) tick();
      if (i == 0) begin
        drive_m(0, 1'b1, 4'd1, 32'h100, 2'd0);
        drive_m(1, 1'b1, 4'd2, 32'h200, 2'd0);
        s_if.arready = 1'b1;
      end
      @(negedge ACLK);
      if (s_if.arvalid && s_if.arready && hs_n < 8) begin
        hs_cyc[hs_n] = i;
        hs_msb[hs_n] = s_if.arid[ID_W];
        hs_n++;
      end
    end
    check("t2_hs_count", hs_n, 4);
    for (int j = 0; j < 4 && j < hs_n; j++) begin
      check("t2_msb", hs_msb[j], (j % 2) == 1);
      check("t2_cycle", hs_cyc[j], 1 + 2 * j);
    end

    // outstanding limit on M1
    do_reset();
    hs_n = 0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) tick();
      if (i == 0) begin drive_m(1, 1'b1, 4'd7, 32'h300, 2'd0); s_if.arready = 1'b1; end
      if (i == 9) begin drive_r(1'b1, 5'h17, 1'b1, 32'h1); m1_if.rready = 1'b1; end
      if (i == 10) s_if.rvalid = 1'b0;
      @(negedge ACLK);
      if (i >= 5 && i <= 9) begin
        check("t3_stall_m1ardy", m1_if.arready, 1'b0);
        check("t3_stall_sav", s_if.arvalid, 1'b0);
      end
      if (m1_if.arvalid && m1_if.arready) begin
        hs_n++;
        if (hs_n == 3) check("t3_third_cycle", i, 11);
      end
    end
    check("t3_hs_count", hs_n, 3);

    // slave backpressure while M0 holds the grant
    do_reset();
    for (int i = 0; i < 9; i++) begin
      if (i > 0) tick();
      if (i == 0) begin
        drive_m(0, 1'b1, 4'd2, 32'h1234, 2'd1);
        drive_m(1, 1'b1, 4'd9, 32'h5678, 2'd2);
      end
      if (i == 7) m0_if.arvalid = 1'b0;
      s_if.arready = (i >= 6);
      @(negedge ACLK);
      if (i >= 1 && i <= 5) begin
        check("t4_sav", s_if.arvalid, 1'b1);
        check("t4_addr_stable", s_if.araddr, 32'h1234);
        check("t4_m1_not_granted", m1_if.arready, 1'b0);
      end
      if (i == 6) check("t4_m0_done", m0_if.arready, 1'b1);
      if (i == 8) begin
        check("t4_m1_next_msb", s_if.arid[ID_W], 1'b1);
        check("t4_m1_next_addr", s_if.araddr, 32'h5678);
      end
    end

    // 4-beat burst to M1 with RREADY toggling
    do_reset();
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      if (i == 0) begin drive_m(1, 1'b1, 4'd5, 32'h400, 2'd3); s_if.arready = 1'b1; end
      if (i == 2) m1_if.arvalid = 1'b0;
      @(negedge ACLK);
    end
    check("t5_cnt_before", dut.cnt_1, 4'd1);
    b = 0;
    c = 0;
    while (b < 4 && c < 20) begin
      tick();
      rdy = c[0];
      m1_if.rready = rdy;
      drive_r(1'b1, 5'h15, b == 3, 32'(b));
      @(negedge ACLK);
      check("t5_srready", s_if.rready, rdy);
      check("t5_m1_rvalid", m1_if.rvalid, 1'b1);
      check("t5_m0_rvalid", m0_if.rvalid, 1'b0);
      check("t5_cnt_mid", dut.cnt_1, 4'd1);
      if (rdy) b++;
      c++;
    end
    tick();
    s_if.rvalid = 1'b0;
    @(negedge ACLK);
    check("t5_beats_done", b, 4);
    check("t5_cnt_after", dut.cnt_1, 4'd0);

    // randomized traffic
    do_reset();
    q_id.delete();
    q_beats.delete();
    for (int i = 0; i < 3000; i++) begin
      rnd_step();
      tick();
    end

    // reset while M1 holds the grant
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      if (i == 0) begin
        drive_m(0, 1'b1, 4'd1, 32'h500, 2'd0);
        drive_m(1, 1'b1, 4'd2, 32'h600, 2'd0);
        drive_r(1'b0, '0, 1'b0, '0);
        s_if.arready = 1'b1;
      end
      if (i == 2) s_if.arready = 1'b0;
      @(negedge ACLK);
      if (i == 3) begin
        check("t6_busy_sav", s_if.arvalid, 1'b1);
        check("t6_busy_msb", s_if.arid[ID_W], 1'b1);
        check("t6_cnt0_pre", dut.cnt_0, 4'd1);
      end
    end
    tick();
    #2;
    ARESETn = 1'b0;
    #1;
    check("t6_async_sav", s_if.arvalid, 1'b0);
    check("t6_async_m1ardy", m1_if.arready, 1'b0);
    check("t6_async_cnt0", dut.cnt_0, 4'd0);
    repeat (2) @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    s_if.arready = 1'b1;
    tick();
    @(negedge ACLK);
    check("t6_post_sav", s_if.arvalid, 1'b1);
    check("t6_post_msb", s_if.arid[ID_W], 1'b0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
